// File: rtl/trace_pkg.sv
// Shared types and helpers for the multi-source trace collector.
// Optional timestamping is enabled with TRACE_TIMESTAMP_EN.
package trace_pkg;

  localparam int DROP_W   = 16;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  localparam int DEF_NSRC = 5;
  localparam int DEF_DW   = 32;
  localparam int DEF_TSW  = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

  // Entry layout {src, ts, data} at the default geometry.
  typedef struct packed {
    logic [clog2(DEF_NSRC)-1:0] src;
    logic [DEF_TSW-1:0]         ts;
    logic [DEF_DW-1:0]          data;
  } entry_t;

endpackage

// File: rtl/trace_collector_if.sv
// Trace source bus and readout port of the trace collector.
// rd_ts exists only when TRACE_TIMESTAMP_EN is defined.
interface trace_collector_if
  import trace_pkg::*;
#(
  parameter int NSRC = 5,
`ifdef TRACE_TIMESTAMP_EN
  parameter int TSW  = 16,
`endif
  parameter int DW   = 32
);

  localparam int SRCW = clog2(NSRC);

  logic [NSRC*DW-1:0] src_data;
  logic [NSRC-1:0]    src_trig;
  logic               rd;
  logic               rd_valid;
  logic [DW-1:0]      rd_data;
  logic [SRCW-1:0]    rd_src;
`ifdef TRACE_TIMESTAMP_EN
  logic [TSW-1:0]     rd_ts;
`endif

`ifdef TRACE_TIMESTAMP_EN
  modport master (
    output src_data, src_trig, rd,
    input  rd_valid, rd_data, rd_src, rd_ts
  );
  modport slave (
    input  src_data, src_trig, rd,
    output rd_valid, rd_data, rd_src, rd_ts
  );
`else
  modport master (
    output src_data, src_trig, rd,
    input  rd_valid, rd_data, rd_src
  );
  modport slave (
    input  src_data, src_trig, rd,
    output rd_valid, rd_data, rd_src
  );
`endif

endinterface

// File: rtl/trace_rr_arbiter.sv
// Round-robin arbiter over pending trace sources.
// Search begins one past the last granted source.
module trace_rr_arbiter
  import trace_pkg::*;
#(
  parameter  int NSRC = 5,
  localparam int SRCW = clog2(NSRC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            en,
  input  logic [NSRC-1:0] req,
  output logic [NSRC-1:0] gnt,
  output logic [SRCW-1:0] idx,
  output logic            any
);

  logic [SRCW-1:0] last_grant;
  logic [SRCW-1:0] c;

  // first requester after last_grant wins
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = '0;
    for (int k = 1; k <= NSRC; k++) begin
      c = SRCW'((int'(last_grant) + k) % NSRC);
      if (en && !any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = c;
      end
    end
  end

  // remember the winner; idle state favours source 0
  always_ff @(posedge clk) begin
    if (!reset || clear) last_grant <= SRCW'(NSRC - 1);
    else if (any)        last_grant <= idx;
  end

endmodule

// File: rtl/trace_collector.sv
// Multi-source trace capture into one circular memory.
// Timestamps are stored when TRACE_TIMESTAMP_EN is defined.
module trace_collector
  import trace_pkg::*;
#(
  parameter  int NSRC  = 5,
  parameter  int DW    = 32,
`ifdef TRACE_TIMESTAMP_EN
  parameter  int TSW   = 16,
`endif
  parameter  int DEPTH = 512,
  localparam int SRCW  = clog2(NSRC),
  localparam int AW    = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  trace_collector_if.slave  bus,
  input  logic              enable,
  input  logic              wrap_mode,
  input  logic              clear,
  output logic [AW:0]       count,
  output logic              full,
  output logic [DROP_W-1:0] drop_cnt,
  output logic [NSRC-1:0]   drop_flags
);

  typedef struct packed {
    logic [SRCW-1:0] src;
`ifdef TRACE_TIMESTAMP_EN
    logic [TSW-1:0]  ts;
`endif
    logic [DW-1:0]   data;
  } ent_t;

  ent_t mem [DEPTH];

  logic [NSRC-1:0]   pend_v;
  logic [DW-1:0]     pend_data [NSRC];
`ifdef TRACE_TIMESTAMP_EN
  logic [TSW-1:0]    pend_ts [NSRC];
  logic [TSW-1:0]    ts_cnt;
`endif

  logic [NSRC-1:0]   gnt;
  logic [SRCW-1:0]   gidx;
  logic              wr_en;
  logic              rd_en;
  logic              room;
  logic [NSRC-1:0]   trig_ok;
  logic [NSRC-1:0]   take;
  logic [NSRC-1:0]   drop;
  int                drop_sum;
  logic [DROP_W-1:0] drop_nxt;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  ent_t              wr_ent;
  ent_t              rd_q;
  logic              rd_vq;

  assign full  = (count == (AW+1)'(DEPTH));
  assign room  = !full || wrap_mode;
  assign rd_en = bus.rd && (count != '0) && !clear;

  trace_rr_arbiter #(.NSRC(NSRC)) u_arb (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .en    (room && !clear),
    .req   (pend_v),
    .gnt   (gnt),
    .idx   (gidx),
    .any   (wr_en)
  );

  // a slot accepts a trigger when empty or draining this cycle
  assign trig_ok = bus.src_trig & {NSRC{enable && !clear}};
  assign take    = trig_ok & (~pend_v | gnt);
  assign drop    = trig_ok & ~take;

  // saturating add of this cycle's drop popcount
  always_comb begin
    drop_sum = int'(drop_cnt);
    for (int i = 0; i < NSRC; i++) drop_sum += int'(drop[i]);
    drop_nxt = (drop_sum > DROP_MAX) ? DROP_W'(DROP_MAX)
                                     : DROP_W'(drop_sum);
  end

  // granted entry assembled from its pending slot
  always_comb begin
    wr_ent      = '0;
    wr_ent.src  = gidx;
    wr_ent.data = pend_data[gidx];
`ifdef TRACE_TIMESTAMP_EN
    wr_ent.ts   = pend_ts[gidx];
`endif
  end

`ifdef TRACE_TIMESTAMP_EN
  // free-running capture timestamp, untouched by clear
  always_ff @(posedge clk) begin
    if (!reset) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + 1'b1;
  end
`endif

  // pending valid bits: set on capture, freed on grant
  always_ff @(posedge clk) begin
    if (!reset || clear) pend_v <= '0;
    else                 pend_v <= (pend_v & ~gnt) | take;
  end

  // pending payload capture
  always_ff @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (take[i]) begin
        pend_data[i] <= bus.src_data[i*DW +: DW];
`ifdef TRACE_TIMESTAMP_EN
        pend_ts[i]   <= ts_cnt;
`endif
      end
    end
  end

  // trace memory write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_ent;
  end

  // registered read port
  always_ff @(posedge clk) begin
    if (!reset)     rd_q <= '0;
    else if (rd_en) rd_q <= mem[rd_ptr];
  end

  // one-cycle valid pulse per accepted read
  always_ff @(posedge clk) begin
    if (!reset) rd_vq <= 1'b0;
    else        rd_vq <= rd_en;
  end

  // pointers and occupancy; a full wrap write drops the oldest
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en || (wr_en && full)) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !rd_en && !full) count <= count + 1'b1;
      else if (rd_en && !wr_en)     count <= count - 1'b1;
    end
  end

  // overrun accounting
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      drop_cnt   <= '0;
      drop_flags <= '0;
    end else begin
      drop_cnt   <= drop_nxt;
      drop_flags <= drop_flags | drop;
    end
  end

  assign bus.rd_valid = rd_vq;
  assign bus.rd_data  = rd_q.data;
  assign bus.rd_src   = rd_q.src;
`ifdef TRACE_TIMESTAMP_EN
  assign bus.rd_ts    = rd_q.ts;
`endif

endmodule

// File: doc/trace_collector.md
# trace_collector

Parametrised multi-source trace capture unit for the MPSoC debug fabric. It accepts trace words and trigger strobes from NSRC sources (tiles plus NoC), arbitrates them round-robin into a single circular trace memory, and tags every entry with its source index. Unlike a fixed-priority mux, simultaneous triggers are held and serialised rather than lost. Overruns are counted, and the memory supports stop-when-full and wrap (keep-latest) modes. It sits at SoC top level between the tile/NoC trace buses and the debug readout logic.

## Interface
- NSRC, 5 — number of trace sources (≥2)
- DW, 32 — trace word width
- DEPTH, 512 — trace memory entries; power of two, ≥4
- TSW, 16 — timestamp width (used only with TRACE_TIMESTAMP_EN)
- Derived: SRCw = log2(NSRC), AW = log2(DEPTH), EW = DW (+TSW with timestamp)

Ports:
- clk  in  1  — single clock
- reset  in  1  — synchronous, active-low reset
- src_data  in  NSRC*DW  — source i occupies bits [(i+1)*DW-1 : i*DW]
- src_trig  in  NSRC  — one-cycle capture strobe per source
- enable  in  1  — capture enable
- wrap_mode  in  1  — 1: overwrite oldest when full; 0: stop when full
- clear  in  1  — synchronous flush
- rd  in  1  — pop oldest entry
- rd_valid  out  1  — rd_data/rd_src/rd_ts valid this cycle
- rd_data  out  DW  — popped trace word
- rd_src  out  SRCw  — source index of popped word
- rd_ts  out  TSW  — capture timestamp (present only with TRACE_TIMESTAMP_EN)
- count  out  AW+1  — entries stored, 0..DEPTH
- full  out  1  — count == DEPTH
- drop_cnt  out  16  — total dropped triggers, saturating
- drop_flags  out  NSRC  — sticky per-source overrun flag

## Operation
- Each source has one pending register (pend_v, pend_data, pend_ts).
- Capture: src_trig[i] && enable loads pend[i] when pend_v[i]=0, or when pend[i] is granted in the same cycle. Otherwise the trigger is dropped: drop_flags[i] is set and drop_cnt increments, saturating at 0xFFFF. Multiple drops in one cycle add their popcount, also saturating.
- enable=0: triggers are ignored without counting drops. Pending entries still drain.
- Arbitration: round-robin over pend_v. Search starts at last_grant+1 modulo NSRC. At most one grant per cycle. last_grant resets to NSRC-1, so source 0 has first priority.
- A grant is issued only if count<DEPTH or wrap_mode=1. In stop mode when full, pending entries wait and later triggers on those sources drop.
- Write: the granted {src, data, ts} goes to mem[wr_ptr], then wr_ptr+1 (wraps mod DEPTH).
- Wrap overwrite when full: rd_ptr also advances and count stays at DEPTH.
- Read: if rd && count>0, mem[rd_ptr] appears on the outputs next cycle with rd_valid=1, and rd_ptr+1. If rd && count==0, the read is ignored and rd_valid=0.
- Simultaneous write and read: count is unchanged. When full in wrap mode, rd_ptr advances once, not twice.
- clear: resets pointers, count, pend_v, drop_cnt, drop_flags and last_grant. It overrides all other activity. The timestamp counter is unaffected.
- Reset values: rd_valid=0, rd_data=0, rd_src=0, rd_ts=0, count=0, full=0, drop_cnt=0, drop_flags=0. Memory contents are not reset.

## Timing
- Trigger on cycle t → pend valid at t+1 → earliest write at edge t+1→t+2 → count reflects it from t+2.
- Worst-case capture latency with all sources pending: NSRC cycles.
- Read latency: rd on cycle t → rd_valid, rd_data on cycle t+1. rd_valid is a one-cycle pulse per accepted rd. Back-to-back reads are allowed every cycle.
- The memory is a simple dual-port array with registered read, inferable as block RAM.

## Configuration
- TRACE_TIMESTAMP_EN defined:
  - A free-running TSW-bit counter (reset to 0, wraps) is sampled into pend_ts at capture.
  - The timestamp is stored per entry and output on rd_ts.
  - EW = DW+TSW.
- Not defined: no counter is built, the rd_ts port is absent, and EW = DW.

## Structure
- Package trace_pkg: the clog2 function, the entry struct typedef {src, ts, data}, and the drop-counter width constant (16).
- Sub-module trace_rr_arbiter: NSRC request bits in, one-hot grant plus SRCw index out, with internal last_grant register and advance on grant.
- Everything else (pending registers, memory, pointers, counters) is in trace_collector.

## Test plan
- Sources 0, 2 and 4 trigger together once with data 0xA0, 0xA2, 0xA4 → entries are written in src order 0, 2, 4 on consecutive cycles; count=3 by t+4; three reads return 0xA0/0, 0xA2/2, 0xA4/4.
- Source 1 triggers on 3 consecutive cycles while sources 0 and 2 are also pending → the third source-1 trigger is dropped; drop_flags=5'b00010, drop_cnt=1.
- wrap_mode=0: write DEPTH+2 words from source 3 → count=512, full=1, pending held, drop_cnt ≥1; first read returns word 0.
- wrap_mode=1: the same stimulus → count=512; first read returns word 2 (oldest two overwritten); full read then write leaves count at 512.
- rd with count=0 → rd_valid stays 0 and pointers are unchanged. Asserting clear mid-burst → count=0, drop_cnt=0, and the next capture goes to address 0.
- Assert reset (low) during active capture → all outputs take their reset values on the next edge; with TRACE_TIMESTAMP_EN, rd_ts of the first post-reset entry equals its capture cycle count.
